// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolve unit: condition codes,
// the 2-bit saturating counter type and its update rule.
package bru_pkg;

    typedef enum logic [2:0] {
        COND_NONE = 3'd0,
        COND_BEQ  = 3'd1,
        COND_BNE  = 3'd2,
        COND_BLT  = 3'd3,
        COND_BGE  = 3'd4,
        COND_BLE  = 3'd5,
        COND_JAL  = 3'd6,
        COND_BGT  = 3'd7
    } cond_e;

    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_INIT_DEFAULT = 2'b01;
    localparam int   PC_INCR          = 4;

    // Counter path 00 <-> 01 <-> 10 <-> 11, saturating at both ends.
    function automatic cnt_t sat_update(input cnt_t cnt, input logic taken);
        if (taken)
            return (cnt == 2'b11) ? cnt : cnt + 2'b01;
        else
            return (cnt == 2'b00) ? cnt : cnt - 2'b01;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch-side prediction and EX-side resolution signals of the branch resolve unit.
// Perf counter outputs exist only when BRU_PERF_COUNTERS_EN is defined.
interface branch_resolve_unit_if #(
    parameter int PC_W = 32
);
    logic [PC_W-1:0] fetch_pc;
    logic            pred_taken;
    logic            ex_valid;
    logic [2:0]      ex_cond;
    logic [PC_W-1:0] ex_pc;
    logic            ex_pred_taken;
    logic [PC_W-1:0] ex_target;
    logic            zero;
    logic            less;
    logic            branch_taken;
    logic            flush;
    logic [PC_W-1:0] redirect_pc;
`ifdef BRU_PERF_COUNTERS_EN
    logic [31:0]     perf_branches;
    logic [31:0]     perf_mispredicts;
`endif

    modport master (
        output fetch_pc, ex_valid, ex_cond, ex_pc, ex_pred_taken, ex_target, zero, less,
        input  pred_taken, branch_taken, flush, redirect_pc
`ifdef BRU_PERF_COUNTERS_EN
        , perf_branches, perf_mispredicts
`endif
    );

    modport slave (
        input  fetch_pc, ex_valid, ex_cond, ex_pc, ex_pred_taken, ex_target, zero, less,
        output pred_taken, branch_taken, flush, redirect_pc
`ifdef BRU_PERF_COUNTERS_EN
        , perf_branches, perf_mispredicts
`endif
    );

endinterface

// File: rtl/bht_counter_table.sv
// Direct-mapped, untagged table of 2-bit saturating counters with one
// combinational read port and one registered update port (no bypass).
module bht_counter_table
    import bru_pkg::*;
#(
    parameter int   PC_W      = 32,
    parameter int   BHT_DEPTH = 64,
    parameter int   IDX_LSB   = 2,
    parameter cnt_t CNT_INIT  = CNT_INIT_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] rd_pc,
    output logic            rd_taken,
    input  logic            wr_en,
    input  logic [PC_W-1:0] wr_pc,
    input  logic            wr_taken
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    cnt_t             table_q [BHT_DEPTH];
    logic             unused_pc_bits;

    assign rd_idx   = rd_pc[IDX_LSB +: IDX_W];
    assign wr_idx   = wr_pc[IDX_LSB +: IDX_W];
    assign rd_taken = table_q[rd_idx][1];

    // Only the index field of each PC matters; the rest is deliberately ignored.
    assign unused_pc_bits = ^{rd_pc, wr_pc};

    // NOTE: the table must come up as CNT_INIT, so every entry is reset here;
    // this costs a reset mux per bit but rules out flop-RAM mapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++)
                table_q[i] <= CNT_INIT;
        end else if (wr_en) begin
            table_q[wr_idx] <= sat_update(table_q[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves branches/JAL in EX, trains the BHT and raises a one-cycle flush with
// redirect PC on mispredict. Optional perf counters: BRU_PERF_COUNTERS_EN.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int   PC_W      = 32,
    parameter int   BHT_DEPTH = 64,
    parameter int   IDX_LSB   = 2,
    parameter cnt_t CNT_INIT  = CNT_INIT_DEFAULT
) (
    input logic                  clk,
    input logic                  reset,
    branch_resolve_unit_if.slave bus
);
    cond_e           cond;
    logic            cond_true;
    logic            taken;
    logic            ev;
    logic            mis;
    logic            flush_q;
    logic [PC_W-1:0] redirect_q;

    assign cond = cond_e'(bus.ex_cond);

    // NOTE: the default assignment before the case keeps this purely
    // combinational; without it a missed arm would infer a latch.
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_BEQ: cond_true = bus.zero;
            COND_BNE: cond_true = ~bus.zero;
            COND_BLT: cond_true = bus.less;
            COND_BGE: cond_true = ~bus.less;
            COND_BLE: cond_true = bus.less | bus.zero;
            COND_BGT: cond_true = ~bus.less & ~bus.zero;
            COND_JAL: cond_true = 1'b1;
            default:  cond_true = 1'b0;
        endcase
    end

    assign taken = bus.ex_valid & cond_true;

    // The op in EX during a flush is wrong-path: no training, no second flush.
    assign ev  = bus.ex_valid & ~flush_q & (cond != COND_NONE);
    assign mis = ev & (taken != bus.ex_pred_taken);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_q    <= 1'b0;
            redirect_q <= '0;
        end else begin
            flush_q <= mis;
            if (mis)
                redirect_q <= taken ? bus.ex_target : bus.ex_pc + PC_W'(PC_INCR);
        end
    end

    assign bus.branch_taken = taken;
    assign bus.flush        = flush_q;
    assign bus.redirect_pc  = redirect_q;

    bht_counter_table #(
        .PC_W      (PC_W),
        .BHT_DEPTH (BHT_DEPTH),
        .IDX_LSB   (IDX_LSB),
        .CNT_INIT  (CNT_INIT)
    ) u_bht (
        .clk      (clk),
        .reset    (reset),
        .rd_pc    (bus.fetch_pc),
        .rd_taken (bus.pred_taken),
        .wr_en    (ev),
        .wr_pc    (bus.ex_pc),
        .wr_taken (taken)
    );

`ifdef BRU_PERF_COUNTERS_EN
    logic [31:0] perf_br_q;
    logic [31:0] perf_mis_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_br_q  <= '0;
            perf_mis_q <= '0;
        end else begin
            if (ev)  perf_br_q  <= perf_br_q + 32'd1;
            if (mis) perf_mis_q <= perf_mis_q + 32'd1;
        end
    end

    assign bus.perf_branches    = perf_br_q;
    assign bus.perf_mispredicts = perf_mis_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit; perf counter checks
// are compiled in when BRU_PERF_COUNTERS_EN is defined.
module tb_branch_resolve_unit;
    import bru_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    branch_resolve_unit_if #(.PC_W(32)) bus_if ();

    branch_resolve_unit #(
        .PC_W      (32),
        .BHT_DEPTH (64),
        .IDX_LSB   (2),
        .CNT_INIT  (2'b01)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [2:0] c, input logic [31:0] pc,
                          input logic [31:0] tgt, input logic pt, input logic z, input logic l);
        bus_if.ex_valid      = v;
        bus_if.ex_cond       = c;
        bus_if.ex_pc         = pc;
        bus_if.ex_target     = tgt;
        bus_if.ex_pred_taken = pt;
        bus_if.zero          = z;
        bus_if.less          = l;
    endtask

    task automatic idle();
        set_ex(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_pred(input string tag, input logic [31:0] pc, input logic expected);
        bus_if.fetch_pc = pc;
        #1;
        check(tag, 32'(bus_if.pred_taken), 32'(expected));
    endtask

    // Expected branch_taken per condition code, bit p for pattern p:
    // p0 = {zero=0,less=0}, p1 = {zero=0,less=1}, p2 = {zero=1,less=0}.
    logic [2:0]  exp_tab [8];
    logic [31:0] idle_pcs [5];

    initial begin
        total = 0;
        bad   = 0;
        exp_tab[0] = 3'b000;  // none
        exp_tab[1] = 3'b100;  // beq
        exp_tab[2] = 3'b011;  // bne
        exp_tab[3] = 3'b010;  // blt
        exp_tab[4] = 3'b101;  // bge
        exp_tab[5] = 3'b110;  // ble
        exp_tab[6] = 3'b111;  // jal
        exp_tab[7] = 3'b001;  // bgt
        idle_pcs[0] = 32'h0000_0000;
        idle_pcs[1] = 32'h0000_0100;
        idle_pcs[2] = 32'h0000_0040;
        idle_pcs[3] = 32'h0000_00FC;
        idle_pcs[4] = 32'hFFFF_FFFF;

        reset = 1'b1;
        bus_if.fetch_pc = 32'h0;
        idle();
        tick();
        tick();

        // Condition sweep while reset is held, so no table or flush state moves.
        for (int c = 0; c < 8; c++) begin
            for (int p = 0; p < 3; p++) begin
                set_ex(1'b1, 3'(c), 32'h10, 32'h20, 1'b0, p == 2, p == 1);
                #1;
                check($sformatf("cond%0d_p%0d", c, p), 32'(bus_if.branch_taken), 32'(exp_tab[c][p]));
            end
        end
        set_ex(1'b0, 3'd6, 32'h10, 32'h20, 1'b0, 1'b0, 1'b0);
        #1;
        check("jal_not_valid", 32'(bus_if.branch_taken), 32'h0);
        idle();
        tick();
        reset = 1'b0;

        // Reset then idle
        check("rst_flush", 32'(bus_if.flush), 32'h0);
        check("rst_redirect", bus_if.redirect_pc, 32'h0);
        foreach (idle_pcs[i])
            check_pred($sformatf("rst_pred_%0d", i), idle_pcs[i], 1'b0);

        // cond none with valid: not an effective op
        set_ex(1'b1, 3'd0, 32'h20, 32'h99, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        check("none_no_flush", 32'(bus_if.flush), 32'h0);
        check_pred("none_no_update", 32'h20, 1'b0);

        // beq taken, predicted not-taken
        set_ex(1'b1, 3'd1, 32'h100, 32'h200, 1'b0, 1'b1, 1'b0);
        bus_if.fetch_pc = 32'h100;
        #1;
        check("beq_taken", 32'(bus_if.branch_taken), 32'h1);
        check("beq_pred_old", 32'(bus_if.pred_taken), 32'h0);
        tick();
        idle();
        #1;
        check("beq_flush", 32'(bus_if.flush), 32'h1);
        check("beq_redirect", bus_if.redirect_pc, 32'h200);
        check_pred("beq_pred_new", 32'h100, 1'b1);
        tick();
        check("beq_flush_drop", 32'(bus_if.flush), 32'h0);
        check("beq_redirect_hold", bus_if.redirect_pc, 32'h200);

        // bne taken four times at 0x40, correctly predicted
        set_ex(1'b1, 3'd2, 32'h40, 32'h80, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("bne_ok_noflush_%0d", k), 32'(bus_if.flush), 32'h0);
        end
        // then not-taken with prediction taken: counter 11 -> 10
        set_ex(1'b1, 3'd2, 32'h40, 32'h80, 1'b1, 1'b1, 1'b0);
        #1;
        check("bne_not_taken", 32'(bus_if.branch_taken), 32'h0);
        tick();
        idle();
        #1;
        check("bne_flush", 32'(bus_if.flush), 32'h1);
        check("bne_redirect", bus_if.redirect_pc, 32'h44);
        check_pred("bne_pred_after_sat", 32'h40, 1'b1);
        tick();
        // one more not-taken: 10 -> 01, prediction drops
        set_ex(1'b1, 3'd2, 32'h40, 32'h80, 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        #1;
        check("bne2_flush", 32'(bus_if.flush), 32'h1);
        check_pred("bne2_pred", 32'h40, 1'b0);
        tick();

        // Back-to-back mispredicts: second is wrong-path
        set_ex(1'b1, 3'd3, 32'h304, 32'h600, 1'b0, 1'b0, 1'b1);
        tick();
        set_ex(1'b1, 3'd1, 32'h308, 32'h500, 1'b0, 1'b1, 1'b0);
        #1;
        check("b2b_flush", 32'(bus_if.flush), 32'h1);
        check("b2b_redirect", bus_if.redirect_pc, 32'h600);
        tick();
        idle();
        #1;
        check("b2b_single_pulse", 32'(bus_if.flush), 32'h0);
        check("b2b_redirect_hold", bus_if.redirect_pc, 32'h600);
        check_pred("b2b_second_untouched", 32'h308, 1'b0);
        check_pred("b2b_first_updated", 32'h304, 1'b1);

        // Same-index lookup and update: no bypass
        set_ex(1'b1, 3'd4, 32'h30C, 32'h700, 1'b0, 1'b0, 1'b0);
        check_pred("same_idx_old", 32'h30C, 1'b0);
        tick();
        idle();
        #1;
        check("bge_flush", 32'(bus_if.flush), 32'h1);
        check("bge_redirect", bus_if.redirect_pc, 32'h700);
        check_pred("same_idx_new", 32'h30C, 1'b1);
        check_pred("alias_idx", 32'h10C, 1'b1);
        tick();

        // Not-taken redirect wraps modulo 2^32
        set_ex(1'b1, 3'd2, 32'hFFFF_FFFC, 32'h1234, 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        #1;
        check("wrap_flush", 32'(bus_if.flush), 32'h1);
        check("wrap_redirect", bus_if.redirect_pc, 32'h0);
        tick();

        // jal mispredict, then reset during the flush cycle
        set_ex(1'b1, 3'd6, 32'h400, 32'h800, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        check("jal_flush", 32'(bus_if.flush), 32'h1);
        check("jal_redirect", bus_if.redirect_pc, 32'h800);
`ifdef BRU_PERF_COUNTERS_EN
        check("perf_branches", bus_if.perf_branches, 32'd11);
        check("perf_mispredicts", bus_if.perf_mispredicts, 32'd7);
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_flush", 32'(bus_if.flush), 32'h0);
        check("rst_mid_redirect", bus_if.redirect_pc, 32'h0);
        check_pred("rst_reinit_100", 32'h100, 1'b0);
        check_pred("rst_reinit_304", 32'h304, 1'b0);
        check_pred("rst_reinit_30c", 32'h30C, 1'b0);
`ifdef BRU_PERF_COUNTERS_EN
        check("perf_br_clear", bus_if.perf_branches, 32'd0);
        check("perf_mis_clear", bus_if.perf_mispredicts, 32'd0);
`endif

        // Correctly predicted not-taken after reset
        set_ex(1'b1, 3'd1, 32'h100, 32'h200, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        check("nt_ok_no_flush", 32'(bus_if.flush), 32'h0);
        check_pred("nt_ok_pred", 32'h100, 1'b0);
`ifdef BRU_PERF_COUNTERS_EN
        check("perf_br_after", bus_if.perf_branches, 32'd1);
        check("perf_mis_after", bus_if.perf_mispredicts, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
